logic_slice_sequencer: RTL and testbench

Initiator/controller for the existing 4-bit combinational logic slice (sel 00=AND, 01=OR, 1x=XOR).
- Accepts a WIDTH-bit MIPS R-type logical operation: funct AND 0x24, OR 0x25, XOR 0x26, NOR 0x27.
- Decodes funct to the slice select code and feeds the slice one nibble per cycle, LSB nibble first.
- Assembles the returned nibbles into a WIDTH-bit result and returns it over a valid/ready handshake.
- Sits between the multi-cycle datapath control and a single shared slice instance, trading area for latency.

---
 rtl/logic_slice_sequencer_pkg.sv | 27 ++
 rtl/logic_slice_sequencer_decode.sv | 21 ++
 rtl/logic_slice_sequencer.sv | 114 +++++++++++
 tb/tb_logic_slice_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/logic_slice_sequencer_pkg.sv
// Shared constants and types for the logic slice sequencer and its funct decoder.
package logic_slice_sequencer_pkg;

  // MIPS R-type funct codes handled by the logic slice
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_NOR = 6'h27;

  // Select codes understood by the 4-bit slice (1x means XOR)
  localparam logic [1:0] SEL_AND = 2'b00;
  localparam logic [1:0] SEL_OR  = 2'b01;
  localparam logic [1:0] SEL_XOR = 2'b10;

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Decoded operation: NOR is an OR pass with the captured nibble inverted
  typedef struct packed {
    logic       legal;
    logic [1:0] sel;
    logic       invert;
  } slice_op_t;

endpackage

// File: rtl/logic_slice_sequencer_decode.sv
// Combinational funct decoder: maps a MIPS funct to slice select, invert and legality.
module logic_funct_decode
  import logic_slice_sequencer_pkg::*;
(
  input  logic [5:0] funct,
  output slice_op_t  op
);

  // Unsupported funct codes decode to a harmless AND with legal cleared
  always_comb begin
    op = '{legal: 1'b0, sel: SEL_AND, invert: 1'b0};
    case (funct)
      FUNCT_AND: op = '{legal: 1'b1, sel: SEL_AND, invert: 1'b0};
      FUNCT_OR:  op = '{legal: 1'b1, sel: SEL_OR,  invert: 1'b0};
      FUNCT_XOR: op = '{legal: 1'b1, sel: SEL_XOR, invert: 1'b0};
      FUNCT_NOR: op = '{legal: 1'b1, sel: SEL_OR,  invert: 1'b1};
      default:   op = '{legal: 1'b0, sel: SEL_AND, invert: 1'b0};
    endcase
  end

endmodule

// File: rtl/logic_slice_sequencer.sv
// Drives a shared 4-bit logic slice one nibble per cycle (LSB first) and assembles
// the WIDTH-bit result, with valid/ready handshakes on both request and result sides.
module logic_slice_sequencer
  import logic_slice_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [5:0]       in_funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_err,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic [1:0]       slice_sel,
  input  logic [3:0]       slice_res
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       sel_reg;
  logic             inv_reg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res_reg;
  logic             err_reg;
  logic [3:0]       nib_cap;
  slice_op_t        op;

  logic_funct_decode u_decode (
    .funct (in_funct),
    .op    (op)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_res   = res_reg;
  assign out_err   = err_reg;
  assign nib_cap   = inv_reg ? ~slice_res : slice_res;

  // Present the current operand nibble to the slice during RUN, zeros otherwise
  always_comb begin
    slice_a   = '0;
    slice_b   = '0;
    slice_sel = '0;
    if (state == ST_RUN) begin
      slice_sel = sel_reg;
      for (int unsigned i = 0; i < NIB; i++) begin
        if (cnt == CW'(i)) begin
          slice_a = a_reg[4*i +: 4];
          slice_b = b_reg[4*i +: 4];
        end
      end
    end
  end

  // Request capture, nibble sequencing and result hand-off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      sel_reg <= '0;
      inv_reg <= 1'b0;
      cnt     <= '0;
      res_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg   <= in_a;
            b_reg   <= in_b;
            sel_reg <= op.sel;
            inv_reg <= op.invert;
            cnt     <= '0;
            res_reg <= '0;
            err_reg <= ~op.legal;
            state   <= op.legal ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          for (int unsigned i = 0; i < NIB; i++) begin
            if (cnt == CW'(i)) res_reg[4*i +: 4] <= nib_cap;
          end
          // Counter stops at the last nibble so it never wraps
          if (cnt == LAST) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state   <= ST_IDLE;
            err_reg <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_slice_sequencer.sv
// Self-checking bench: directed test-plan vectors plus random operations,
// checked against a word-level reference model of the logical operations.
module tb_logic_slice_sequencer;

  localparam int WIDTH = 32;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [5:0]       in_funct;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_err;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [1:0]       slice_sel;
  logic [3:0]       slice_res;

  int unsigned total;
  int unsigned passed;
  int unsigned fails;

  logic_slice_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_funct  (in_funct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_err   (out_err),
    .slice_a   (slice_a),
    .slice_b   (slice_b),
    .slice_sel (slice_sel),
    .slice_res (slice_res)
  );

  // The existing 4-bit combinational logic slice
  always_comb begin
    case (slice_sel)
      2'b00:   slice_res = slice_a & slice_b;
      2'b01:   slice_res = slice_a | slice_b;
      default: slice_res = slice_a ^ slice_b;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word-level meaning of each funct code
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                       output logic [31:0] r, output logic e, output logic [1:0] s);
    e = 1'b0;
    case (f)
      6'h24:   begin r = a & b;    s = 2'b00; end
      6'h25:   begin r = a | b;    s = 2'b01; end
      6'h26:   begin r = a ^ b;    s = 2'b10; end
      6'h27:   begin r = ~(a | b); s = 2'b01; end
      default: begin r = '0;       s = 2'b00; e = 1'b1; end
    endcase
  endtask

  // One complete transaction starting in IDLE, #1 after a rising edge.
  // Optionally holds a follow-on request on the input during the DONE stall.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                       input int unsigned stall, input logic pend,
                       input logic [31:0] pa, input logic [31:0] pb, input logic [5:0] pf);
    logic [31:0] er;
    logic        ee;
    logic [1:0]  es;
    int unsigned lat;
    int unsigned exp_lat;
    model(a, b, f, er, ee, es);
    // Legal ops need one edge per nibble; illegal ones reach DONE on the accept edge
    exp_lat = ee ? 0 : NIB;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_funct  = f;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_funct = 6'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (lat < NIB) begin
        check("slice_a_nib", 32'(slice_a), 32'(a[4*lat +: 4]));
        check("slice_b_nib", 32'(slice_b), 32'(b[4*lat +: 4]));
      end
      check("slice_sel_run", 32'(slice_sel), 32'(es));
      check("in_ready_run", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    for (int unsigned c = 0; c <= stall; c++) begin
      if (pend && c < stall) begin
        in_valid = 1'b1;
        in_a     = pa;
        in_b     = pb;
        in_funct = pf;
      end
      check("out_valid_done", 32'(out_valid), 32'd1);
      check("out_res", out_res, er);
      check("out_err", 32'(out_err), 32'(ee));
      check("slice_idle_done", {22'd0, slice_sel, slice_a, slice_b}, 32'd0);
      check("in_ready_done", 32'(in_ready), 32'd0);
      if (c < stall) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_clear", 32'(out_valid), 32'd0);
    check("out_err_clear", 32'(out_err), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [5:0]  rf;
    int unsigned r;
    total     = 0;
    passed    = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_funct  = '0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_out_res", out_res, 32'd0);
    check("rst_slice", {22'd0, slice_sel, slice_a, slice_b}, 32'd0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed test-plan vectors
    do_op(32'hF0F01234, 32'h0FF0FFFF, 6'h24, 0, 1'b0, '0, '0, '0);
    do_op(32'h12000034, 32'h00341200, 6'h25, 0, 1'b0, '0, '0, '0);
    do_op(32'hFFFF0000, 32'h0F0F0F0F, 6'h26, 0, 1'b0, '0, '0, '0);
    do_op(32'h00000000, 32'h00000000, 6'h27, 0, 1'b0, '0, '0, '0);
    do_op(32'hAAAAAAAA, 32'h55555555, 6'h27, 0, 1'b0, '0, '0, '0);
    do_op(32'h12345678, 32'h9ABCDEF0, 6'h20, 0, 1'b0, '0, '0, '0);
    do_op(32'h0000FFFF, 32'h00FF00FF, 6'h25, 0, 1'b0, '0, '0, '0);

    // Backpressure with a follow-on request waiting; it is accepted right after release
    do_op(32'hDEADBEEF, 32'hFFFF0000, 6'h24, 5, 1'b1, 32'h0F0F0F0F, 32'h3C3C3C3C, 6'h26);
    do_op(32'h0F0F0F0F, 32'h3C3C3C3C, 6'h26, 0, 1'b0, '0, '0, '0);

    // Abort in the middle of RUN at k=3
    in_valid = 1'b1;
    in_a     = $urandom;
    in_b     = $urandom;
    in_funct = 6'h26;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("pre_abort_nib", 32'(slice_a), 32'(in_a[15:12]));
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_err", 32'(out_err), 32'd0);
    check("abort_out_res", out_res, 32'd0);
    check("abort_slice", {22'd0, slice_sel, slice_a, slice_b}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(32'h00000001, 32'h00000003, 6'h26, 0, 1'b0, '0, '0, '0);

    // Random operations, mostly legal, with random result backpressure
    for (int n = 0; n < 24; n++) begin
      r  = $urandom_range(0, 5);
      rf = (r < 4) ? 6'h24 + 6'(r) : 6'($urandom_range(0, 63));
      do_op($urandom, $urandom, rf, $urandom_range(0, 3), 1'b0, '0, '0, '0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule
